// File: rtl/seq_pattern_tx_if.sv
// Start-request and serial-output bundle for seq_pattern_tx.
// The requester drives the master modport; the transmitter uses the slave modport.
interface seq_pattern_tx_if #(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8
);
   // A request is accepted on a rising edge where start_valid && start_ready.
   // start_ready depends only on transmitter state. pat_in and rep_in are sampled
   // on that edge only. While start_ready is low, start_valid is ignored and nothing is queued.
   logic [PAT_W-1:0] pat_in;
   logic [CNT_W-1:0] rep_in;
   logic             start_valid;
   logic             start_ready;
   logic             sdo;
   logic             sdo_valid;
   logic             busy;
   logic             done;

   modport master (
      output pat_in, rep_in, start_valid,
      input  start_ready, sdo, sdo_valid, busy, done
   );

   modport slave (
      input  pat_in, rep_in, start_valid,
      output start_ready, sdo, sdo_valid, busy, done
   );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a captured PAT_W-bit pattern MSB-first, rep_in times,
// with GAP_LEN idle cycles between copies. Define SEQ_TX_PARITY_EN to append an even-parity bit to each copy.
module seq_pattern_tx #(
   parameter int PAT_W   = 4,
   parameter int CNT_W   = 8,
   parameter int GAP_LEN = 0
) (
   input  logic             clk,
   input  logic             reset,
   seq_pattern_tx_if.slave  tx_if,
   output logic [1:0]       state_o
);

`ifdef SEQ_TX_PARITY_EN
   localparam int FRAME = PAT_W + 1;
`else
   localparam int FRAME = PAT_W;
`endif
   localparam int BIT_W = $clog2(FRAME);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME - 1);
   localparam int GAP_LAST_I = (GAP_LEN > 0) ? GAP_LEN - 1 : 0;
   localparam logic [3:0] GAP_LAST = GAP_LAST_I[3:0];

   // Debug encoding seen on state_o: IDLE=0, SEND=1, GAP=2, DONE=3.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t             state_q;
   logic [FRAME-1:0]   shreg_q;
   logic [PAT_W-1:0]   pat_q;
   logic [CNT_W-1:0]   copies_q;
   logic [BIT_W-1:0]   bit_q;
   logic [3:0]         gap_q;
   logic               sdo_q;
   logic               sdo_valid_q;
   logic               busy_q;
   logic               done_q;
   logic               ready_q;
   logic [FRAME-1:0]   in_frame;
   logic [FRAME-1:0]   pat_frame;

   function automatic logic [FRAME-1:0] frame_of(input logic [PAT_W-1:0] p);
`ifdef SEQ_TX_PARITY_EN
      return {p, ^p};
`else
      return p;
`endif
   endfunction

   assign in_frame  = frame_of(tx_if.pat_in);
   assign pat_frame = frame_of(pat_q);

   // Outputs are registered alongside the state, so sdo always equals shreg_q's MSB while in SEND.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         shreg_q     <= '0;
         pat_q       <= '0;
         copies_q    <= '0;
         bit_q       <= '0;
         gap_q       <= '0;
         sdo_q       <= 1'b0;
         sdo_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         ready_q     <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (tx_if.start_valid && ready_q) begin
                  pat_q    <= tx_if.pat_in;
                  copies_q <= tx_if.rep_in;
                  ready_q  <= 1'b0;
                  busy_q   <= 1'b1;
                  if (tx_if.rep_in != '0) begin
                     state_q     <= SEND;
                     shreg_q     <= in_frame;
                     sdo_q       <= in_frame[FRAME-1];
                     sdo_valid_q <= 1'b1;
                     bit_q       <= '0;
                  end else begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            SEND: begin
               if (bit_q == BIT_LAST) begin
                  copies_q <= copies_q - CNT_W'(1);
                  bit_q    <= '0;
                  if (copies_q == CNT_W'(1)) begin
                     state_q     <= DONE;
                     sdo_q       <= 1'b0;
                     sdo_valid_q <= 1'b0;
                     done_q      <= 1'b1;
                  end else if (GAP_LEN > 0) begin
                     state_q     <= GAP;
                     sdo_q       <= 1'b0;
                     sdo_valid_q <= 1'b0;
                     gap_q       <= '0;
                  end else begin
                     // Back-to-back copy: reload without a bubble.
                     shreg_q <= pat_frame;
                     sdo_q   <= pat_frame[FRAME-1];
                  end
               end else begin
                  bit_q   <= bit_q + BIT_W'(1);
                  shreg_q <= {shreg_q[FRAME-2:0], 1'b0};
                  sdo_q   <= shreg_q[FRAME-2];
               end
            end
            GAP: begin
               if (gap_q == GAP_LAST) begin
                  state_q     <= SEND;
                  shreg_q     <= pat_frame;
                  sdo_q       <= pat_frame[FRAME-1];
                  sdo_valid_q <= 1'b1;
                  bit_q       <= '0;
               end else begin
                  gap_q <= gap_q + 4'd1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
            end
            default: begin
               state_q     <= IDLE;
               sdo_q       <= 1'b0;
               sdo_valid_q <= 1'b0;
               done_q      <= 1'b0;
               busy_q      <= 1'b0;
               ready_q     <= 1'b1;
            end
         endcase
      end
   end

   assign tx_if.start_ready = ready_q;
   assign tx_if.sdo         = sdo_q;
   assign tx_if.sdo_valid   = sdo_valid_q;
   assign tx_if.busy        = busy_q;
   assign tx_if.done        = done_q;
   assign state_o           = state_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: one instance without gaps and one with GAP_LEN=2, driven by a directed
// vector table, reset corner sequences and random requests checked against a stream model.
module tb_seq_pattern_tx;
   localparam int PAT_W = 4;
   localparam int CNT_W = 8;
   localparam int W     = 5;   // observed word: {sdo, sdo_valid, busy, done, start_ready}

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] state0;
   logic [1:0] state2;

   seq_pattern_tx_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus0 ();
   seq_pattern_tx_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus2 ();

   seq_pattern_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_LEN(0)) u_dut0 (
      .clk(clk), .reset(reset), .tx_if(bus0), .state_o(state0)
   );
   seq_pattern_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_LEN(2)) u_dut2 (
      .clk(clk), .reset(reset), .tx_if(bus2), .state_o(state2)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- scoreboard ----------------
   int checks   = 0;
   int failures = 0;
   logic [W-1:0] exp_q[$];

   typedef struct {
      bit           sel;
      logic [3:0]   pat;
      logic [7:0]   rep;
      bit           hold;
      string        exp;
   } vec_t;
   vec_t vecs[$];

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%b exp=%b (sdo,vld,busy,done,rdy) t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic check2(input string name, input logic [1:0] act, input logic [1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%b exp=%b t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] obs(input bit sel);
      if (sel) return {bus2.sdo, bus2.sdo_valid, bus2.busy, bus2.done, bus2.start_ready};
      return {bus0.sdo, bus0.sdo_valid, bus0.busy, bus0.done, bus0.start_ready};
   endfunction

   // Stream model: '1'/'0' = valid data bit, '-' = gap cycle.
   function automatic string model(input logic [3:0] pat, input int rep, input int gap);
      string s    = "";
      string one  = "1";
      string zero = "0";
      string dash = "-";
      for (int k = 0; k < rep; k++) begin
         for (int i = PAT_W - 1; i >= 0; i--) s = {s, pat[i] ? one : zero};
`ifdef SEQ_TX_PARITY_EN
         s = {s, (^pat) ? one : zero};
`endif
         if (k < rep - 1) for (int g = 0; g < gap; g++) s = {s, dash};
      end
      return s;
   endfunction

   // ---------------- drivers ----------------
   task automatic set_start(input bit sel, input bit v, input logic [3:0] p, input logic [7:0] r);
      if (sel) begin
         bus2.start_valid = v; bus2.pat_in = p; bus2.rep_in = r;
      end else begin
         bus0.start_valid = v; bus0.pat_in = p; bus0.rep_in = r;
      end
   endtask

   task automatic add_vec(input bit sel, input logic [3:0] pat, input logic [7:0] rep,
                          input bit hold, input string exp);
      vec_t v;
      v.sel = sel; v.pat = pat; v.rep = rep; v.hold = hold; v.exp = exp;
      vecs.push_back(v);
   endtask

   // Handshake, then compare every cycle through done and the following idle cycle.
   task automatic run_txn(input bit sel, input logic [3:0] pat, input logic [7:0] rep,
                          input bit hold, input string exp);
      byte ch;
      for (int i = 0; i < exp.len(); i++) begin
         ch = exp[i];
         if (ch == "-") exp_q.push_back(5'b00100);
         else           exp_q.push_back({ch == "1", 4'b1100});
      end
      exp_q.push_back(5'b00110);
      exp_q.push_back(5'b00001);
      set_start(sel, 1'b1, pat, rep);
      @(posedge clk);
      #1;
      set_start(sel, hold, 4'($urandom), 8'($urandom));
      while (exp_q.size() > 0) begin
         @(negedge clk);
         check(sel ? "stream_gap2" : "stream_gap0", obs(sel), exp_q.pop_front());
         if (hold) set_start(sel, 1'b1, 4'($urandom), 8'($urandom));
      end
      set_start(sel, 1'b0, 4'($urandom), 8'($urandom));
   endtask

   // ---------------- test ----------------
   initial begin
      bit         sel;
      logic [3:0] pat;
      logic [7:0] rep;
      bit         hold;

      reset = 1'b1;
      set_start(1'b0, 1'b0, 4'd0, 8'd0);
      set_start(1'b1, 1'b0, 4'd0, 8'd0);
      repeat (2) @(negedge clk);
      check("reset_vals0", obs(1'b0), 5'b00001);
      check("reset_vals2", obs(1'b1), 5'b00001);
      check2("reset_state", state0, 2'd0);
      reset = 1'b0;

`ifdef SEQ_TX_PARITY_EN
      add_vec(1'b0, 4'b1011, 8'd1, 1'b0, "10111");
      add_vec(1'b0, 4'b1010, 8'd3, 1'b0, "101001010010100");
      add_vec(1'b1, 4'b1010, 8'd2, 1'b0, "10100--10100");
      add_vec(1'b0, 4'b1010, 8'd2, 1'b1, "1010010100");
`else
      add_vec(1'b0, 4'b1010, 8'd1, 1'b0, "1010");
      add_vec(1'b0, 4'b1010, 8'd3, 1'b0, "101010101010");
      add_vec(1'b1, 4'b1010, 8'd2, 1'b0, "1010--1010");
      add_vec(1'b0, 4'b1010, 8'd2, 1'b1, "10101010");
      add_vec(1'b1, 4'b0111, 8'd3, 1'b0, "0111--0111--0111");
`endif
      add_vec(1'b0, 4'b0110, 8'd0, 1'b0, "");
      add_vec(1'b1, 4'b1100, 8'd0, 1'b1, "");

      foreach (vecs[i]) run_txn(vecs[i].sel, vecs[i].pat, vecs[i].rep, vecs[i].hold, vecs[i].exp);

      // Reset during the 2nd bit of copy 1 of a 3-copy transfer.
      @(negedge clk);
      set_start(1'b0, 1'b1, 4'b1010, 8'd3);
      @(posedge clk);
      #1;
      set_start(1'b0, 1'b0, 4'b0000, 8'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      check("bit2_before_rst", obs(1'b0), 5'b01100);
      @(negedge clk);
      check("rst_mid_frame", obs(1'b0), 5'b00001);
      check2("rst_mid_state", state0, 2'd0);
      reset = 1'b0;
      repeat (4) begin
         @(negedge clk);
         check("rst_quiet", obs(1'b0), 5'b00001);
      end
      run_txn(1'b0, 4'b0110, 8'd1, 1'b0, model(4'b0110, 1, 0));

      // Reset during a gap cycle.
      set_start(1'b1, 1'b1, 4'b1010, 8'd3);
      @(posedge clk);
      #1;
      set_start(1'b1, 1'b0, 4'b0000, 8'd0);
      repeat (PAT_W) @(posedge clk);
`ifdef SEQ_TX_PARITY_EN
      @(posedge clk);
`endif
      #1;
      @(negedge clk);
      check("gap_cycle", obs(1'b1), 5'b00100);
      reset = 1'b1;
      @(negedge clk);
      check("rst_mid_gap", obs(1'b1), 5'b00001);
      reset = 1'b0;

      // Reset wins over a simultaneous handshake.
      reset = 1'b1;
      set_start(1'b0, 1'b1, 4'b1111, 8'd2);
      @(negedge clk);
      check("rst_prio", obs(1'b0), 5'b00001);
      reset = 1'b0;
      set_start(1'b0, 1'b0, 4'b0000, 8'd0);
      @(negedge clk);
      check("rst_prio_idle", obs(1'b0), 5'b00001);

      // Randomised requests against the stream model.
      for (int n = 0; n < 30; n++) begin
         sel  = 1'($urandom_range(0, 1));
         pat  = 4'($urandom);
         rep  = 8'($urandom_range(0, 4));
         hold = 1'($urandom_range(0, 1));
         run_txn(sel, pat, rep, hold, model(pat, int'(rep), sel ? 2 : 0));
      end

      // Maximum copy count.
      pat = 4'($urandom);
      run_txn(1'b0, pat, 8'd255, 1'b0, model(pat, 255, 0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
